// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: launches NPAR parallel requests and an NSEQ-step
// sequential chain after a start, then joins (or aborts on timeout).
module fork_join_ctrl #(
  parameter int NPAR    = 3,
  parameter int NSEQ    = 3,
  parameter int DELAY   = 2,
  parameter int TIMEOUT = 64
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [NPAR-1:0] par_req,
  input  logic [NPAR-1:0] par_ack,
  output logic [NSEQ-1:0] seq_req,
  input  logic            seq_ack,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [NPAR-1:0] par_done
);

  localparam int SW = (NSEQ > 1)    ? $clog2(NSEQ)      : 1;
  localparam int DW = (DELAY > 0)   ? $clog2(DELAY+1)   : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;
  localparam logic [SW-1:0] LAST = SW'(NSEQ-1);
  localparam logic [DW-1:0] DLY  = DW'(DELAY);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT-1);

  typedef enum logic [1:0] {IDLE, WAIT_DLY, RUN, JOIN} state_e;

  state_e          state_q, state_d;
  logic [NPAR-1:0] par_req_q, par_req_d;
  logic [NPAR-1:0] par_done_q, par_done_d;
  logic            seq_on_q, seq_on_d;
  logic [SW-1:0]   sidx_q, sidx_d;
  logic            gap_on_q, gap_on_d;
  logic [DW-1:0]   gap_q, gap_d;
  logic            seq_fin_q, seq_fin_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            timeout_q, timeout_d;

  logic [NPAR-1:0] par_acc;
  logic            seq_acc;
  logic            do_launch;
  logic            join_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      par_req_q  <= '0;
      par_done_q <= '0;
      seq_on_q   <= 1'b0;
      sidx_q     <= '0;
      gap_on_q   <= 1'b0;
      gap_q      <= '0;
      seq_fin_q  <= 1'b0;
      tmo_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      par_req_q  <= par_req_d;
      par_done_q <= par_done_d;
      seq_on_q   <= seq_on_d;
      sidx_q     <= sidx_d;
      gap_on_q   <= gap_on_d;
      gap_q      <= gap_d;
      seq_fin_q  <= seq_fin_d;
      tmo_q      <= tmo_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    par_req_d  = par_req_q;
    par_done_d = par_done_q;
    seq_on_d   = seq_on_q;
    sidx_d     = sidx_q;
    gap_on_d   = gap_on_q;
    gap_d      = gap_q;
    seq_fin_d  = seq_fin_q;
    tmo_d      = tmo_q;
    timeout_d  = timeout_q;
    do_launch  = 1'b0;
    join_now   = 1'b0;
    par_acc    = par_ack & par_req_q;
    seq_acc    = seq_ack & seq_on_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          par_done_d = '0;
          seq_fin_d  = 1'b0;
          timeout_d  = 1'b0;
          gap_d      = DW'(1);
          if (DELAY == 0) do_launch = 1'b1;
          else            state_d   = WAIT_DLY;
        end
      end
      WAIT_DLY: begin
        // gap_q holds the number of edges elapsed since the start edge
        if (gap_q == DLY) do_launch = 1'b1;
        else              gap_d     = gap_q + DW'(1);
      end
      RUN: begin
        par_req_d  = par_req_q & ~par_ack;
        par_done_d = par_done_q | par_acc;
        tmo_d      = (&tmo_q) ? tmo_q : tmo_q + TW'(1);
        if (seq_acc) begin
          seq_on_d = 1'b0;
          if (sidx_q == LAST) begin
            seq_fin_d = 1'b1;
          end else begin
            // index advances now; the request stays low through the gap
            sidx_d = sidx_q + SW'(1);
            if (DELAY == 0) seq_on_d = 1'b1;
            else begin
              gap_on_d = 1'b1;
              gap_d    = DW'(1);
            end
          end
        end else if (gap_on_q) begin
          if (gap_q == DLY) begin
            seq_on_d = 1'b1;
            gap_on_d = 1'b0;
          end else begin
            gap_d = gap_q + DW'(1);
          end
        end
        join_now = (&par_done_d) && seq_fin_d;
        if (join_now) begin
          state_d = JOIN;
        end else if (tmo_q >= TLIM) begin
          state_d   = JOIN;
          timeout_d = 1'b1;
          par_req_d = '0;
          seq_on_d  = 1'b0;
          gap_on_d  = 1'b0;
        end
      end
      JOIN: begin
        state_d   = IDLE;
        timeout_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (do_launch) begin
      state_d   = RUN;
      par_req_d = '1;
      seq_on_d  = 1'b1;
      sidx_d    = '0;
      gap_on_d  = 1'b0;
      tmo_d     = '0;
    end
  end

  for (genvar k = 0; k < NSEQ; k++) begin : g_seq
    assign seq_req[k] = seq_on_q && (sidx_q == SW'(k));
  end

  assign par_req  = par_req_q;
  assign par_done = par_done_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == JOIN);
  assign timeout  = timeout_q;

endmodule

// File: doc/fork_join_ctrl.md
FORK_JOIN_CTRL -- requirements
Module: fork_join_ctrl

Interface
REQ-001 SHALL have parameter NPAR, default 3, number of parallel branches.
REQ-002 SHALL have parameter NSEQ, default 3, number of steps in the sequential branch.
REQ-003 SHALL have parameter DELAY, default 2, gap in cycles before each launch (0 permitted).
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum cycles from first launch to join.
REQ-005 SHALL provide clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL provide rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL provide start, input, 1, fork request pulse.
REQ-008 SHALL provide par_req, output, NPAR, per-branch request.
REQ-009 SHALL provide par_ack, input, NPAR, per-branch completion.
REQ-010 SHALL provide seq_req, output, NSEQ, one-hot step request.
REQ-011 SHALL provide seq_ack, input, 1, completion of the current step.
REQ-012 SHALL provide busy, output, 1, high from fork until join completes.
REQ-013 SHALL provide done, output, 1, one-cycle join pulse.
REQ-014 SHALL provide timeout, output, 1, one-cycle pulse coincident with done on a timeout abort.
REQ-015 SHALL provide par_done, output, NPAR, sticky per-branch completion flags for the current run.

Function
REQ-016 SHALL implement states IDLE, WAIT_DLY, RUN and JOIN.
REQ-017 In IDLE, start sampled high at edge T SHALL clear par_done, set busy after T and enter WAIT_DLY, or RUN directly if DELAY=0.
REQ-018 After the start at edge T, all par_req bits and seq_req[0] SHALL rise together after edge T+DELAY, with no request high before that.
REQ-019 par_req[i] SHALL stay high until par_ack[i] is sampled high; it SHALL then fall after that edge, and par_done[i] SHALL set after that edge.
REQ-020 par_ack[i] sampled while par_req[i] is low SHALL be ignored.
REQ-021 seq_ack sampled with seq_req[k] high SHALL drop seq_req[k] after that edge E.
REQ-022 For k<NSEQ-1, seq_req[k+1] SHALL then rise after edge E+DELAY.
REQ-023 seq_ack sampled while seq_req is all-zero SHALL be ignored.
REQ-024 Parallel and sequential acks in the same cycle SHALL all be accepted.
REQ-025 Join SHALL be reached when all par_done bits are set and the final seq_ack has been accepted; if that occurs at edge J, done SHALL be high for the cycle after J.
REQ-026 busy SHALL stay high through the done cycle and fall after edge J+1 (state returns to IDLE).
REQ-027 The timeout counter SHALL clear at launch and count every cycle, including sequential gaps, until join.
REQ-028 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits wide, saturating.
REQ-029 If join is not reached by edge L+TIMEOUT (L = launch edge), all requests SHALL drop after that edge, and done and timeout SHALL pulse together in the next cycle.
REQ-030 par_done SHALL hold its partial value after a timeout abort until the next accepted start.
REQ-031 A join completing on the same edge the timeout count is reached SHALL win: done=1, timeout=0.
REQ-032 start while busy=1, including the done cycle, SHALL be ignored and not queued.
REQ-033 The RTL SHALL be synthesizable, with no delays, fork/join constructs or initial blocks.

Reset
REQ-034 rst high at an edge SHALL force IDLE after that edge with par_req, seq_req, busy, done, timeout and par_done all 0 and counters cleared, including mid-run.
REQ-035 rst SHALL take priority over start and all acks sampled on the same edge.

Verification (defaults NPAR=3, NSEQ=3, DELAY=2, TIMEOUT=64)
REQ-036 Reset: rst held for 2 edges with random start/acks -> all outputs 0; rst asserted mid-RUN -> all outputs 0 after that edge, and the next start runs normally.
REQ-037 Nominal: start at edge 0, bench acks each request one cycle after it rises -> par_req=3'b111 and seq_req=3'b001 after edge 2; par_done=3'b111 after edge 3; seq_req=3'b010 after edge 5, 3'b100 after edge 8; done=1 after edge 9; busy=0 after edge 10.
REQ-038 Out-of-order: par_ack[2] at edge 3, par_ack[0] at edge 7, par_ack[1] at edge 20, plus a spurious par_ack[2] at edge 10 -> par_done evolves 100, 101, 111; the spurious ack has no effect; done after edge 20.
REQ-039 Timeout: par_ack[1] never driven -> par_req=3'b010 until edge 66; done=1 and timeout=1 after edge 66; par_done=3'b101; busy=0 after edge 67.
REQ-040 Busy start: start pulsed at edges 4 and 9 during a run, and in the done cycle -> no restart, no second done.
REQ-041 Priority: the final ack sampled exactly at edge 66 -> done=1 with timeout=0.
